cfg_word_loader: RTL and testbench

Configuration loader that sits directly upstream of the basic logic element's SRAM configuration cells. It accepts a serial configuration bitstream with a valid/ready handshake and packs it into DATA_SIZE-bit words. It drives each word on DATA and pulses the matching group of STROBE lines with setup and hold margins. The STROBE mapping is STROBE[DATA_SIZE*w+k] ↔ DATA[k], and a short final word is used when STROBE_SIZE is not a multiple of DATA_SIZE.

---
 rtl/cfg_loader_pkg.sv | 33 +++
 rtl/cfg_strobe_dec.sv | 30 +++
 rtl/cfg_word_loader.sv | 151 +++++++++++++++
 tb/tb_cfg_word_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cfg_loader_pkg                                              |
// | Brief  : Shared state encoding and word-geometry helpers for the     |
// |          configuration word loader.                                  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } cfg_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int calc_nb_words(input int strobe_size, input int data_size);
        return ceil_div(strobe_size, data_size);
    endfunction

    // Width of the final group; equals data_size when the cells divide evenly.
    function automatic int calc_last_bits(input int strobe_size, input int data_size);
        return strobe_size - data_size * (calc_nb_words(strobe_size, data_size) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_strobe_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cfg_strobe_dec                                              |
// | Brief  : Word index to per-cell strobe mask, short final group.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module cfg_strobe_dec
    import cfg_loader_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int STROBE_SIZE = 17,
    parameter int WORD_W      = 2
) (
    input  logic [WORD_W-1:0]      i_word_idx,
    input  logic                   i_en,
    output logic [STROBE_SIZE-1:0] o_strobe
);

    localparam int NB_WORDS  = calc_nb_words(STROBE_SIZE, DATA_SIZE);
    localparam int LAST_BITS = calc_last_bits(STROBE_SIZE, DATA_SIZE);

    for (genvar w = 0; w < NB_WORDS; w++) begin : g_group
        localparam int GW = (w == NB_WORDS - 1) ? LAST_BITS : DATA_SIZE;
        logic w_sel;
        assign w_sel = i_en && (i_word_idx == WORD_W'(w));
        assign o_strobe[DATA_SIZE*w +: GW] = {GW{w_sel}};
    end

endmodule
`default_nettype wire

// File: rtl/cfg_word_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cfg_word_loader                                             |
// | Brief  : Packs a serial bitstream into words and strobes them into   |
// |          the SRAM config cells with setup/hold margins.              |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module cfg_word_loader
    import cfg_loader_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int STROBE_SIZE = 17,
    parameter int WR_CYCLES   = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CFG_START,
    input  logic                   CFG_BIT,
    input  logic                   CFG_VALID,
    output logic                   CFG_READY,
    output logic [DATA_SIZE-1:0]   DATA,
    output logic [STROBE_SIZE-1:0] STROBE,
    output logic                   CFG_BUSY,
    output logic                   CFG_DONE
);

    localparam int NB_WORDS  = calc_nb_words(STROBE_SIZE, DATA_SIZE);
    localparam int LAST_BITS = calc_last_bits(STROBE_SIZE, DATA_SIZE);
    localparam int BIT_W     = $clog2(DATA_SIZE + 1);
    localparam int WORD_W    = $clog2(NB_WORDS + 1);
    localparam int WR_W      = $clog2(WR_CYCLES + 1);

    localparam logic [BIT_W-1:0]  FULL_CNT  = BIT_W'(DATA_SIZE);
    localparam logic [BIT_W-1:0]  LAST_CNT  = BIT_W'(LAST_BITS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NB_WORDS - 1);
    localparam logic [WR_W-1:0]   WR_LAST   = WR_W'(WR_CYCLES - 1);

    cfg_state_e            state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
    logic [WR_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [DATA_SIZE-1:0]  shreg_q, shreg_d;
    logic [DATA_SIZE-1:0]  data_q, data_d;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_last_word;
    logic [BIT_W-1:0]      w_need;
    logic                  w_word_full;
    logic                  w_strobe_en;

    assign w_start     = (state_q == IDLE || state_q == DONE) && CFG_START;
    assign w_accept    = (state_q == SHIFT) && CFG_VALID;
    assign w_last_word = (word_cnt_q == LAST_WORD);
    assign w_need      = w_last_word ? LAST_CNT : FULL_CNT;
    assign w_word_full = ((bit_cnt_q + BIT_W'(1)) == w_need);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (CFG_START) state_d = SHIFT;
            SHIFT:      if (w_accept && w_word_full) state_d = SETUP;
            SETUP:      state_d = WRITE;
            WRITE:      if (wr_cnt_q == WR_LAST) state_d = HOLD;
            HOLD:       state_d = w_last_word ? DONE : SHIFT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        CFG_READY   = (state_q == SHIFT);
        CFG_BUSY    = (state_q inside {SHIFT, SETUP, WRITE, HOLD});
        CFG_DONE    = (state_q == DONE);
        w_strobe_en = (state_q == WRITE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            wr_cnt_q   <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;

        if (w_start) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            shreg_d    = '0;
        end

        if (w_accept) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                if (bit_cnt_q == BIT_W'(i)) shreg_d[i] = CFG_BIT;
            end
            // Clearing the shift register per word keeps the unused upper
            // bits of a short final word at zero on DATA.
            if (w_word_full) begin
                data_d    = shreg_d;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end

        if (state_q == WRITE) begin
            wr_cnt_d = (wr_cnt_q == WR_LAST) ? '0 : wr_cnt_q + WR_W'(1);
        end

        if (state_q == HOLD && !w_last_word) begin
            word_cnt_d = word_cnt_q + WORD_W'(1);
        end
    end

    assign DATA = data_q;

    cfg_strobe_dec #(
        .DATA_SIZE   (DATA_SIZE),
        .STROBE_SIZE (STROBE_SIZE),
        .WORD_W      (WORD_W)
    ) u_strobe_dec (
        .i_word_idx (word_cnt_q),
        .i_en       (w_strobe_en),
        .o_strobe   (STROBE)
    );

endmodule
`default_nettype wire

// File: tb/tb_cfg_word_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_cfg_word_loader                                          |
// | Brief  : Scoreboard bench for cfg_word_loader (17/8/1 and 16/8/3).   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cfg_word_loader;

    localparam int DS   = 8;
    localparam int SS_A = 17;
    localparam int WR_A = 1;
    localparam int SS_B = 16;
    localparam int WR_B = 3;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] s;
    } win_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic start_r [2];
    logic valid_r [2];
    logic bit_r   [2];

    wire          rdy_w  [2];
    wire          busy_w [2];
    wire          done_w [2];
    wire [DS-1:0] data_w [2];
    wire [SS_A-1:0] strobe_a;
    wire [SS_B-1:0] strobe_b;
    wire [31:0]   strb [2];

    assign strb[0] = 32'(strobe_a);
    assign strb[1] = 32'(strobe_b);

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    win_t        sb0[$];
    win_t        sb1[$];
    logic [31:0] prev_s [2];
    logic [31:0] prev_d [2];
    logic [31:0] win_d  [2];
    int          hi     [2];
    logic        prev_done [2];

    always #5 CLK = ~CLK;

    cfg_word_loader #(.DATA_SIZE(DS), .STROBE_SIZE(SS_A), .WR_CYCLES(WR_A)) u_dut_a (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CFG_START (start_r[0]),
        .CFG_BIT   (bit_r[0]),
        .CFG_VALID (valid_r[0]),
        .CFG_READY (rdy_w[0]),
        .DATA      (data_w[0]),
        .STROBE    (strobe_a),
        .CFG_BUSY  (busy_w[0]),
        .CFG_DONE  (done_w[0])
    );

    cfg_word_loader #(.DATA_SIZE(DS), .STROBE_SIZE(SS_B), .WR_CYCLES(WR_B)) u_dut_b (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CFG_START (start_r[1]),
        .CFG_BIT   (bit_r[1]),
        .CFG_VALID (valid_r[1]),
        .CFG_READY (rdy_w[1]),
        .DATA      (data_w[1]),
        .STROBE    (strobe_b),
        .CFG_BUSY  (busy_w[1]),
        .CFG_DONE  (done_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ss_of(input int i);  return (i == 0) ? SS_A : SS_B; endfunction
    function automatic int wr_of(input int i);  return (i == 0) ? WR_A : WR_B; endfunction
    function automatic int nb_of(input int i);  return (ss_of(i) + DS - 1) / DS; endfunction
    function automatic int last_of(input int i); return ss_of(i) - DS * (nb_of(i) - 1); endfunction

    function automatic logic [31:0] model_strobe(input int i, input int w);
        int width;
        width = (w == nb_of(i) - 1) ? last_of(i) : DS;
        return ((32'd1 << width) - 32'd1) << (DS * w);
    endfunction

    task automatic push_exp(input int i, input logic [31:0] d, input logic [31:0] s);
        win_t e;
        e.d = d;
        e.s = s;
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic drive(input int i, input logic s, input logic v, input logic b);
        start_r[i] = s;
        valid_r[i] = v;
        bit_r[i]   = b;
    endtask

    // Window monitor: pops one expectation per STROBE rising edge.
    task automatic mon_step(input int i);
        logic [31:0] s;
        logic [31:0] d;
        win_t        e;
        s = strb[i];
        d = 32'(data_w[i]);
        if (!RST_N) begin
            prev_s[i] = '0; prev_d[i] = '0; win_d[i] = '0; hi[i] = 0; prev_done[i] = 1'b0;
            return;
        end
        if (s != 0 && prev_s[i] == 0) begin
            check_eq("setup_stable", d, prev_d[i]);
            if (sb_size(i) == 0) begin
                check_eq("unexpected_window", s, 32'd0);
            end else begin
                if (i == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check_eq("win_data", d, e.d);
                check_eq("win_strobe", s, e.s);
            end
            win_d[i] = d;
            hi[i]    = 1;
        end else if (s != 0) begin
            hi[i]++;
            check_eq("strobe_steady", s, prev_s[i]);
        end else if (prev_s[i] != 0) begin
            check_eq("hold_stable", d, win_d[i]);
            check_eq("write_len", 32'(hi[i]), 32'(wr_of(i)));
        end
        if (done_w[i] && !prev_done[i]) check_eq("done_strobe_zero", s, 32'd0);
        prev_s[i]    = s;
        prev_d[i]    = d;
        prev_done[i] = done_w[i];
    endtask

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) mon_step(i);
    end

    task automatic run_load(input int inst, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int gap_pct, input bit start_mid,
                            input int rst_word, output int lat_o);
        logic [7:0]  words [3];
        bit          bq[$];
        int          nb, nbits, idx;
        logic [31:0] m;
        logic        s, v, b;
        words = '{w0, w1, w2};
        nb = nb_of(inst);
        for (int w = 0; w < nb; w++) begin
            nbits = (w == nb - 1) ? last_of(inst) : DS;
            for (int k = 0; k < nbits; k++) bq.push_back(words[w][k]);
            m = (32'd1 << nbits) - 32'd1;
            push_exp(inst, 32'(words[w]) & m, model_strobe(inst, w));
        end

        @(negedge CLK);
        drive(inst, 1'b1, (gap_pct == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge CLK);
        lat_o = -1;
        idx   = 0;
        for (int c = 0; c < 2000; c++) begin
            if (done_w[inst]) begin
                lat_o = c;
                break;
            end
            if (c == 0) begin
                check_eq("start_busy", 32'(busy_w[inst]), 32'd1);
                check_eq("start_done_clr", 32'(done_w[inst]), 32'd0);
            end
            if (rst_word >= 0 && strb[inst] == model_strobe(inst, rst_word)) begin
                #2 RST_N = 1'b0;
                #1;
                check_eq("rst_strobe", strb[inst], 32'd0);
                check_eq("rst_data", 32'(data_w[inst]), 32'd0);
                check_eq("rst_busy", 32'(busy_w[inst]), 32'd0);
                check_eq("rst_ready", 32'(rdy_w[inst]), 32'd0);
                lat_o = -2;
                break;
            end
            s = start_mid && (c == 14);
            b = 1'($urandom_range(0, 1));
            if (rdy_w[inst]) begin
                v = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
                if (v && idx < bq.size()) b = bq[idx];
                if (v) idx++;
            end else begin
                v = (gap_pct == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            drive(inst, s, v, b);
            @(negedge CLK);
        end
        drive(inst, 1'b0, 1'b0, 1'b0);
        if (lat_o == -1) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_ready", 32'(rdy_w[i]), 32'd0);
            check_eq("reset_busy", 32'(busy_w[i]), 32'd0);
            check_eq("reset_done", 32'(done_w[i]), 32'd0);
            check_eq("reset_data", 32'(data_w[i]), 32'd0);
            check_eq("reset_strobe", strb[i], 32'd0);
        end
        RST_N = 1'b1;

        // VALID in IDLE must not be consumed
        drive(0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge CLK);
        check_eq("idle_ready", 32'(rdy_w[0]), 32'd0);
        check_eq("idle_busy", 32'(busy_w[0]), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0);

        run_load(0, 8'hA5, 8'h3C, 8'h01, 0, 1'b0, -1, lat);
        check_eq("latency_a", 32'(lat), 32'd26);
        check_eq("sb_empty_1", 32'(sb0.size()), 32'd0);
        check_eq("done_flag", 32'(done_w[0]), 32'd1);
        check_eq("done_busy", 32'(busy_w[0]), 32'd0);
        check_eq("done_data", 32'(data_w[0]), 32'h01);
        check_eq("done_strobe", strb[0], 32'd0);

        run_load(0, 8'h5E, 8'hC7, 8'h00, 40, 1'b0, -1, lat);
        check_eq("gap_latency_ge", 32'(lat >= 26), 32'd1);
        check_eq("sb_empty_gap", 32'(sb0.size()), 32'd0);

        run_load(0, 8'h12, 8'h34, 8'h01, 0, 1'b1, -1, lat);
        check_eq("latency_restart_ignored", 32'(lat), 32'd26);
        check_eq("sb_empty_restart", 32'(sb0.size()), 32'd0);

        run_load(0, 8'hFF, 8'h81, 8'h01, 0, 1'b0, 1, lat);
        check_eq("rst_abort", 32'(lat), 32'hFFFF_FFFE);
        repeat (2) @(negedge CLK);
        sb0.delete();
        RST_N = 1'b1;
        drive(0, 1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge CLK);
        check_eq("post_rst_strobe", strb[0], 32'd0);
        check_eq("post_rst_ready", 32'(rdy_w[0]), 32'd0);
        check_eq("post_rst_busy", 32'(busy_w[0]), 32'd0);
        check_eq("post_rst_done", 32'(done_w[0]), 32'd0);
        check_eq("post_rst_data", 32'(data_w[0]), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0);

        run_load(0, 8'h77, 8'hEE, 8'h01, 0, 1'b0, -1, lat);
        check_eq("latency_after_rst", 32'(lat), 32'd26);
        check_eq("sb_empty_after_rst", 32'(sb0.size()), 32'd0);

        run_load(1, 8'h5A, 8'hC3, 8'h00, 0, 1'b0, -1, lat);
        check_eq("latency_b", 32'(lat), 32'd26);
        check_eq("sb_empty_b", 32'(sb1.size()), 32'd0);
        check_eq("done_data_b", 32'(data_w[1]), 32'hC3);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
